// File: rtl/weight_sparse_encoder.sv
// weight_sparse_encoder: compresses one dense weight slice (channel-major, r fastest)
// into a packed nonzero list {val, r, k} plus per-channel cumulative end pointers.
// Optional feature macro: ENC_THRESH_EN (adds i_thresh, magnitude-threshold zero test).
module weight_sparse_encoder #(
  parameter int unsigned K_LEN  = 8,
  parameter int unsigned R_LEN  = 3,
  parameter int unsigned VAL_BW = 8,
  parameter int unsigned MAX_NZ = 24,
  localparam int unsigned RW    = (R_LEN > 1) ? $clog2(R_LEN) : 1,
  localparam int unsigned KW    = (K_LEN > 1) ? $clog2(K_LEN) : 1,
  localparam int unsigned PW    = $clog2(MAX_NZ) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [VAL_BW-1:0] i_data,
`ifdef ENC_THRESH_EN
  input  logic [VAL_BW-2:0] i_thresh,
`endif
  output logic              o_ready,
  output logic [VAL_BW-1:0] o_val [0:MAX_NZ-1],
  output logic [RW-1:0]     o_r   [0:MAX_NZ-1],
  output logic [KW-1:0]     o_k   [0:MAX_NZ-1],
  output logic [PW-1:0]     o_ptr [0:K_LEN-1],
  output logic [PW-1:0]     o_length,
  output logic              o_overflow,
  output logic              o_finish
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic              r_ready;
  logic              r_finish;
  logic              r_overflow;
  logic [PW-1:0]     r_length;
  logic [RW-1:0]     r_rcnt;
  logic [KW-1:0]     r_kcnt;
  logic [VAL_BW-1:0] r_val [0:MAX_NZ-1];
  logic [RW-1:0]     r_r   [0:MAX_NZ-1];
  logic [KW-1:0]     r_k   [0:MAX_NZ-1];
  logic [PW-1:0]     r_ptr [0:K_LEN-1];

  logic              w_acc;
  logic              w_nz;
  logic              w_room;
  logic              w_last_r;
  logic              w_last;
  logic [PW-1:0]     w_len_nxt;

`ifdef ENC_THRESH_EN
  logic [VAL_BW-2:0] r_thresh;
  logic [VAL_BW-1:0] w_abs;
  logic [VAL_BW-2:0] w_mag;

  // Saturated magnitude of the signed input compared against the latched threshold
  always_comb begin
    w_abs = i_data[VAL_BW-1] ? (~i_data + VAL_BW'(1)) : i_data;
    w_mag = w_abs[VAL_BW-1] ? '1 : w_abs[VAL_BW-2:0];
    w_nz  = (w_mag > r_thresh);
  end

  // Threshold is captured with the start of each slice
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_thresh <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_thresh <= i_thresh;
    end
  end
`else
  // Only an exact zero is skipped
  always_comb begin
    w_nz = (i_data != '0);
  end
`endif

  // Accept / position decode and post-update length
  always_comb begin
    w_acc     = i_valid && r_ready;
    w_room    = (r_length < PW'(MAX_NZ));
    w_last_r  = (r_rcnt == RW'(R_LEN - 1));
    w_last    = w_last_r && (r_kcnt == KW'(K_LEN - 1));
    w_len_nxt = (w_nz && w_room) ? (r_length + PW'(1)) : r_length;
  end

  // Control FSM with list, pointer and counter updates
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_finish   <= 1'b0;
      r_overflow <= 1'b0;
      r_length   <= '0;
      r_rcnt     <= '0;
      r_kcnt     <= '0;
      for (int i = 0; i < int'(MAX_NZ); i++) begin
        r_val[i] <= '0;
        r_r[i]   <= '0;
        r_k[i]   <= '0;
      end
      for (int j = 0; j < int'(K_LEN); j++) begin
        r_ptr[j] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_finish <= 1'b0;
          if (i_start) begin
            r_state    <= S_RUN;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
            r_length   <= '0;
            r_rcnt     <= '0;
            r_kcnt     <= '0;
            for (int i = 0; i < int'(MAX_NZ); i++) begin
              r_val[i] <= '0;
              r_r[i]   <= '0;
              r_k[i]   <= '0;
            end
            for (int j = 0; j < int'(K_LEN); j++) begin
              r_ptr[j] <= '0;
            end
          end
        end
        S_RUN: begin
          if (w_acc) begin
            if (w_nz) begin
              if (w_room) begin
                for (int i = 0; i < int'(MAX_NZ); i++) begin
                  if (PW'(i) == r_length) begin
                    r_val[i] <= i_data;
                    r_r[i]   <= r_rcnt;
                    r_k[i]   <= r_kcnt;
                  end
                end
                r_length <= w_len_nxt;
              end else begin
                r_overflow <= 1'b1;
              end
            end
            if (w_last_r) begin
              for (int j = 0; j < int'(K_LEN); j++) begin
                if (KW'(j) == r_kcnt) begin
                  r_ptr[j] <= w_len_nxt;
                end
              end
              r_rcnt <= '0;
              r_kcnt <= r_kcnt + KW'(1);
            end else begin
              r_rcnt <= r_rcnt + RW'(1);
            end
            if (w_last) begin
              r_state  <= S_DONE;
              r_ready  <= 1'b0;
              r_finish <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_finish <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_finish   = r_finish;
  assign o_overflow = r_overflow;
  assign o_length   = r_length;
  assign o_val      = r_val;
  assign o_r        = r_r;
  assign o_k        = r_k;
  assign o_ptr      = r_ptr;

endmodule

// File: tb/tb_weight_sparse_encoder.sv
// Testbench for weight_sparse_encoder: two instances (MAX_NZ 24 and 20) share one
// stimulus stream; results are checked against a list-building reference model.
module tb_weight_sparse_encoder;

  localparam int N = 24;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic       i_valid;
  logic [7:0] i_data;
`ifdef ENC_THRESH_EN
  logic [6:0] i_thresh;
`endif

  logic       rdy24, fin24, ovf24;
  logic [7:0] val24 [24];
  logic [1:0] r24   [24];
  logic [2:0] k24   [24];
  logic [5:0] ptr24 [8];
  logic [5:0] len24;

  logic       rdy20, fin20, ovf20;
  logic [7:0] val20 [20];
  logic [1:0] r20   [20];
  logic [2:0] k20   [20];
  logic [5:0] ptr20 [8];
  logic [5:0] len20;

  int n_vec = 0;
  int n_err = 0;
  int th_cur = 0;

  always #5 i_clk = ~i_clk;

  weight_sparse_encoder #(.K_LEN(8), .R_LEN(3), .VAL_BW(8), .MAX_NZ(24)) dut24 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
`ifdef ENC_THRESH_EN
    .i_thresh(i_thresh),
`endif
    .o_ready(rdy24), .o_val(val24), .o_r(r24), .o_k(k24), .o_ptr(ptr24),
    .o_length(len24), .o_overflow(ovf24), .o_finish(fin24));

  weight_sparse_encoder #(.K_LEN(8), .R_LEN(3), .VAL_BW(8), .MAX_NZ(20)) dut20 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
`ifdef ENC_THRESH_EN
    .i_thresh(i_thresh),
`endif
    .o_ready(rdy20), .o_val(val20), .o_r(r20), .o_k(k20), .o_ptr(ptr20),
    .o_length(len20), .o_overflow(ovf20), .o_finish(fin20));

  typedef struct {
    logic signed [7:0] d [24];
    bit                gaps;
    bit                extra;
    int                exp_len24;
    int                exp_len20;
    int                exp_ovf20;
  } vec_t;

  vec_t tbl [6];

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the dense slice, append nonzeros while there is room
  task automatic model(input logic signed [7:0] d [24], input int maxnz, input int th,
                       output int len, output int ovf, output int ev [24],
                       output int er [24], output int ek [24], output int ep [8]);
    int a;
    len = 0; ovf = 0;
    for (int i = 0; i < N; i++) begin ev[i] = 0; er[i] = 0; ek[i] = 0; end
    for (int n = 0; n < N; n++) begin
      a = int'(d[n]);
      if (a < 0) a = -a;
      if (a > 127) a = 127;
      if (a > th) begin
        if (len < maxnz) begin
          ev[len] = int'(d[n]); er[len] = n % 3; ek[len] = n / 3; len++;
        end else begin
          ovf = 1;
        end
      end
      if (n % 3 == 2) ep[n / 3] = len;
    end
  endtask

  task automatic check_all(input logic signed [7:0] d [24], input int tag);
    int len, ovf;
    int ev [24]; int er [24]; int ek [24]; int ep [8];
    string t;
    t = $sformatf("v%0d", tag);
    model(d, 24, th_cur, len, ovf, ev, er, ek, ep);
    cmp({t, " len24"}, int'(len24), len);
    cmp({t, " ovf24"}, int'(ovf24), ovf);
    cmp({t, " rdy24"}, int'(rdy24), 0);
    for (int j = 0; j < 8; j++) cmp($sformatf("%s ptr24[%0d]", t, j), int'(ptr24[j]), ep[j]);
    for (int i = 0; i < 24; i++) begin
      cmp($sformatf("%s val24[%0d]", t, i), int'($signed(val24[i])), ev[i]);
      cmp($sformatf("%s r24[%0d]", t, i), int'(r24[i]), er[i]);
      cmp($sformatf("%s k24[%0d]", t, i), int'(k24[i]), ek[i]);
    end
    model(d, 20, th_cur, len, ovf, ev, er, ek, ep);
    cmp({t, " len20"}, int'(len20), len);
    cmp({t, " ovf20"}, int'(ovf20), ovf);
    for (int j = 0; j < 8; j++) cmp($sformatf("%s ptr20[%0d]", t, j), int'(ptr20[j]), ep[j]);
    for (int i = 0; i < 20; i++) begin
      cmp($sformatf("%s val20[%0d]", t, i), int'($signed(val20[i])), ev[i]);
      cmp($sformatf("%s r20[%0d]", t, i), int'(r20[i]), er[i]);
      cmp($sformatf("%s k20[%0d]", t, i), int'(k20[i]), ek[i]);
    end
  endtask

  task automatic check_zero(input string t);
    cmp({t, " rdy"}, int'(rdy24) + int'(rdy20), 0);
    cmp({t, " fin"}, int'(fin24) + int'(fin20), 0);
    cmp({t, " ovf"}, int'(ovf24) + int'(ovf20), 0);
    cmp({t, " len24"}, int'(len24), 0);
    cmp({t, " len20"}, int'(len20), 0);
    for (int j = 0; j < 8; j++) cmp($sformatf("%s ptr[%0d]", t, j), int'(ptr24[j]) + int'(ptr20[j]), 0);
    for (int i = 0; i < 24; i++) cmp($sformatf("%s ent24[%0d]", t, i), int'(val24[i]) + int'(r24[i]) + int'(k24[i]), 0);
    for (int i = 0; i < 20; i++) cmp($sformatf("%s ent20[%0d]", t, i), int'(val20[i]) + int'(r20[i]) + int'(k20[i]), 0);
  endtask

  // Drives one slice; returns the negedge count after start at which o_finish was seen
  task automatic run_slice(input logic signed [7:0] d [24], input bit gaps, input bit extra,
                           input int abort_at, output int fin_cyc);
    int idx, cyc;
    bit acc;
    idx = 0; cyc = 0; fin_cyc = -1;
    @(negedge i_clk);
`ifdef ENC_THRESH_EN
    i_thresh = 7'(th_cur);
`endif
    i_start = 1'b1; i_valid = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0;
    while (fin_cyc < 0 && cyc < 400 && idx != abort_at) begin
      if (idx < N) begin
        i_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        i_data  = d[idx];
      end else begin
        i_valid = 1'b0;
      end
      i_start = (extra && idx < N) ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = i_valid && rdy24;
      @(negedge i_clk);
      cyc++;
      if (acc) idx++;
      if (fin24) fin_cyc = cyc;
    end
    i_start = 1'b0; i_valid = 1'b0;
    if (abort_at < 0) begin
      cmp("finish_seen", int'(fin_cyc >= 0), 1);
      cmp("finish_pair", int'(fin24), int'(fin20));
      @(negedge i_clk);
      cmp("finish_one_cycle", int'(fin24) + int'(fin20), 0);
      cmp("ready_after_done", int'(rdy24) + int'(rdy20), 0);
    end
  endtask

  initial begin
    int fc;
    logic signed [7:0] d [24];

    for (int t = 0; t < 6; t++) begin
      for (int n = 0; n < N; n++) tbl[t].d[n] = 8'sd0;
      tbl[t].gaps = 1'b0; tbl[t].extra = 1'b0;
    end
    // all zero
    tbl[0].exp_len24 = 0;  tbl[0].exp_len20 = 0;  tbl[0].exp_ovf20 = 0;
    // single 5 at element 7 (k=2, r=1)
    tbl[1].d[7] = 8'sd5;
    tbl[1].exp_len24 = 1;  tbl[1].exp_len20 = 1;  tbl[1].exp_ovf20 = 0;
    // every element nonzero
    for (int n = 0; n < N; n++) tbl[2].d[n] = (n % 2 == 1) ? 8'(-(n + 1)) : 8'(n + 1);
    tbl[2].exp_len24 = 24; tbl[2].exp_len20 = 20; tbl[2].exp_ovf20 = 1;
    // same as 1 and 2 with gapped valid and stray starts
    tbl[3] = tbl[1]; tbl[3].gaps = 1'b1; tbl[3].extra = 1'b1;
    tbl[4] = tbl[2]; tbl[4].gaps = 1'b1; tbl[4].extra = 1'b1;
    // even elements nonzero, includes the most negative value
    for (int n = 0; n < N; n += 2) tbl[5].d[n] = (n == 0) ? -8'sd128 : 8'(n);
    tbl[5].exp_len24 = 12; tbl[5].exp_len20 = 12; tbl[5].exp_ovf20 = 0;

    i_rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_data = 8'h00;
`ifdef ENC_THRESH_EN
    i_thresh = 7'd0;
`endif
    repeat (3) @(negedge i_clk);
    check_zero("reset");
    i_rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      run_slice(tbl[t].d, tbl[t].gaps, tbl[t].extra, -1, fc);
      if (!tbl[t].gaps) cmp($sformatf("v%0d finish_cycle", t), fc + 1, 25);
      cmp($sformatf("v%0d tbl_len24", t), int'(len24), tbl[t].exp_len24);
      cmp($sformatf("v%0d tbl_len20", t), int'(len20), tbl[t].exp_len20);
      cmp($sformatf("v%0d tbl_ovf20", t), int'(ovf20), tbl[t].exp_ovf20);
      cmp($sformatf("v%0d tbl_ptr_end", t), int'(ptr24[7]), tbl[t].exp_len24);
      check_all(tbl[t].d, t);
    end

    // Spot checks on the capacity-20 instance
    d = tbl[2].d;
    run_slice(d, 1'b0, 1'b0, -1, fc);
    cmp("cap20 ptr6", int'(ptr20[6]), 20);
    cmp("cap20 ptr7", int'(ptr20[7]), 20);
    cmp("cap20 e19 k", int'(k20[19]), 6);
    cmp("cap20 e19 r", int'(r20[19]), 1);

    for (int t = 0; t < 20; t++) begin
      for (int n = 0; n < N; n++) d[n] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'sd0;
      run_slice(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, fc);
      check_all(d, 100 + t);
    end

    // Abort mid-slice with reset, then encode a fresh slice
    d = tbl[2].d;
    run_slice(d, 1'b0, 1'b0, 10, fc);
    cmp("pre_abort len", int'(len24), 10);
    i_rst_n = 1'b0;
    #1;
    check_zero("abort");
    @(negedge i_clk);
    check_zero("abort_hold");
    i_rst_n = 1'b1;
    cmp("abort no finish", int'(fin24), 0);
    run_slice(tbl[1].d, 1'b0, 1'b0, -1, fc);
    cmp("after_abort finish_cycle", fc + 1, 25);
    check_all(tbl[1].d, 200);

`ifdef ENC_THRESH_EN
    for (int n = 0; n < N; n++) d[n] = 8'sd0;
    d[0] = -8'sd2; d[1] = 8'sd3; d[2] = -8'sd128;
    th_cur = 2;
    run_slice(d, 1'b0, 1'b0, -1, fc);
    cmp("thr len", int'(len24), 2);
    cmp("thr e0", int'($signed(val24[0])), 3);
    cmp("thr e1", int'($signed(val24[1])), -128);
    check_all(d, 300);
    th_cur = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weight_sparse_encoder.md
# weight_sparse_encoder

Compresses one dense weight slice (filter column `s`) into the sparse form consumed by the address-to-RF expander: a packed list of nonzero values with their kernel-row index `r` and output-channel index `k`, plus a per-channel cumulative end pointer. It sits between the weight loader (dense stream in) and the address/RF generation stage (parallel arrays out). It runs once per slice and signals completion with a one-cycle finish pulse.

## Interface
- `K_LEN`, default 8: output channels per slice.
- `R_LEN`, default 3: kernel rows per channel.
- `VAL_BW`, default 8: signed weight width.
- `MAX_NZ`, default 24: nonzero list capacity, at most `K_LEN*R_LEN`.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  begin a slice; sampled only in IDLE.
- `i_valid`  in  1  dense element valid.
- `i_data`  in  VAL_BW  dense weight, signed.
- `o_ready`  out  1  encoder accepts an element this cycle.
- `o_val[0:MAX_NZ-1]`  out  VAL_BW each  packed nonzero values.
- `o_r[0:MAX_NZ-1]`  out  clog2(R_LEN) each  kernel row per entry.
- `o_k[0:MAX_NZ-1]`  out  clog2(K_LEN) each  channel per entry.
- `o_ptr[0:K_LEN-1]`  out  clog2(MAX_NZ)+1 each  cumulative nonzero count through channel k.
- `o_length`  out  clog2(MAX_NZ)+1  total stored entries.
- `o_overflow`  out  1  sticky; nonzeros were dropped.
- `o_finish`  out  1  one-cycle pulse, slice complete.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset enters IDLE.
  - IDLE to RUN on `i_start`. The same edge clears `o_val`, `o_r`, `o_k`, `o_ptr`, `o_length`, `o_overflow`, and the element counter.
  - RUN to DONE on the edge that accepts element `K_LEN*R_LEN-1`.
  - DONE to IDLE unconditionally after one cycle.
- Dense order: channel-major, `r` fastest. Element n maps to k = n / R_LEN and r = n % R_LEN. Track this with separate r and k counters, not a divider.
- An element is accepted when `i_valid && o_ready`. `o_ready` = 1 only in RUN.
- Accepted nonzero with `o_length < MAX_NZ`:
  - write `o_val`, `o_r`, `o_k` at index `o_length`;
  - increment `o_length`.
- Accepted nonzero with `o_length == MAX_NZ`: drop the element, set `o_overflow`, leave `o_length` unchanged.
- Accepted element with r == R_LEN-1: write `o_ptr[k]` with the post-update `o_length`. A channel with no nonzeros gets `o_ptr[k]` = previous pointer (0 for k=0).
- Outputs hold their values in DONE and IDLE until the next `i_start`.
- `i_start` in RUN or DONE is ignored. There is no abort; `i_rst_n` is the only way to cancel a slice.

## Timing
- Reset values: all outputs 0, including `o_ready`, `o_finish`, all arrays, `o_length`, `o_overflow`.
- Throughput: one element per cycle while `i_valid` is held high. Stalls from `i_valid` = 0 add cycles but do not change results.
- Latency: the first element can be accepted in the cycle after `i_start` is sampled. `o_finish` is high the cycle after the last accept, i.e. in DONE. Best-case total is K_LEN*R_LEN + 1 cycles from start to finish.
- All array, length and pointer updates become visible the cycle after the accepting edge. When `o_finish` = 1, every output is final.
- Asynchronous reset mid-RUN: all state and outputs return to reset values immediately. No `o_finish` is produced.
- The last accept writes both the final entry and `o_ptr[K_LEN-1]` on the same edge. `o_ptr[K_LEN-1]` == `o_length` holds at finish.

## Configuration
- `ENC_THRESH_EN`
  - Defined: adds input `i_thresh` (VAL_BW-1 bits, unsigned), latched on `i_start`. An element counts as zero when |`i_data`| <= latched threshold. The magnitude of the most negative value saturates to 2^(VAL_BW-1)-1 before comparison.
  - Undefined: no `i_thresh` port. An element counts as zero only when `i_data` == 0.

## Test plan
- All-zero slice, K_LEN=8, R_LEN=3, contiguous valid -> `o_length`=0, every `o_ptr`=0, `o_overflow`=0, `o_finish` high exactly on cycle 25 after start.
- Single nonzero 5 at element 7 (k=2, r=1) -> entry 0 = {val 5, r 1, k 2}; `o_ptr`=0,0,1,1,1,1,1,1; `o_length`=1.
- All 24 elements nonzero with MAX_NZ=20 -> `o_length`=20, `o_overflow`=1, `o_ptr[6]`=20, `o_ptr[7]`=20, entry 19 = (k=6, r=1).
- Random `i_valid` gaps with 50% duty -> arrays identical to the gap-free run; `o_ready` never high outside RUN; extra `i_start` pulses during RUN have no effect.
- Assert `i_rst_n` low after 10 accepts, then restart -> all outputs 0 during reset; the following slice encodes correctly with no residue from the aborted slice.
- With `ENC_THRESH_EN`, `i_thresh`=2 and inputs -2, 3, -128 -> only 3 and -128 stored; -128 stored unchanged.
